// File: rtl/aclock_multi_alarm.sv
// -----------------------------------------------------------------------------
// aclock_multi_alarm
//   24-hour real-time clock with N_ALARMS programmable alarm slots, snooze and
//   ring timeout. One second elapses per rising edge of clk_1s.
//
//   Ports
//     clk_1s     1 Hz tick clock, every rising edge is one second
//     reset      asynchronous, active-high; clears time, slots and FSM
//     ld_time    load hh:mm from h_in*/m_in*, seconds become 00
//     ld_alarm   load slot alarm_sel with hh:mm from h_in*/m_in*
//     alarm_sel  slot index written by ld_alarm
//     h_in1/h_in0/m_in1/m_in0  BCD hour/minute digits for both loads
//     al_en      per-slot alarm enable
//     stop_al    stop ringing or snoozing, back to idle
//     snooze     while ringing: silence, re-ring after SNOOZE_SEC seconds
//     h_out1..s_out0  BCD digits of the current time (decoded from counters)
//     alarm      buzzer, high while ringing
//     alarm_id   slot that caused the current ring/snooze (held in idle)
//     snoozing   high while snoozing
//     load_err   one-cycle pulse after a rejected ld_time/ld_alarm
//
//   A rejected load leaves the time and the slots untouched by that load; the
//   clock itself keeps running. ld_time and ld_alarm share the input digits
//   and are accepted independently of each other.
// -----------------------------------------------------------------------------
module aclock_multi_alarm #(
  parameter int N_ALARMS   = 4,
  parameter int AW         = 2,
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60
) (
  input  logic                clk_1s,
  input  logic                reset,
  input  logic                ld_time,
  input  logic                ld_alarm,
  input  logic [AW-1:0]       alarm_sel,
  input  logic [1:0]          h_in1,
  input  logic [3:0]          h_in0,
  input  logic [3:0]          m_in1,
  input  logic [3:0]          m_in0,
  input  logic [N_ALARMS-1:0] al_en,
  input  logic                stop_al,
  input  logic                snooze,
  output logic [1:0]          h_out1,
  output logic [3:0]          h_out0,
  output logic [3:0]          m_out1,
  output logic [3:0]          m_out0,
  output logic [3:0]          s_out1,
  output logic [3:0]          s_out0,
  output logic                alarm,
  output logic [AW-1:0]       alarm_id,
  output logic                snoozing,
  output logic                load_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  localparam logic [11:0] RING_LAST = 12'(RING_SEC - 1);
  localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_SEC - 1);

  // Two BCD digits to binary; only meaningful for in-range digits.
  function automatic logic [5:0] to_bin(input logic [3:0] tens, input logic [3:0] units);
    return (6'(tens) * 6'd10) + 6'(units);
  endfunction

  // Input digits form a legal 24-hour hh:mm.
  function automatic logic digits_ok(input logic [1:0] h1, input logic [3:0] h0,
                                     input logic [3:0] m1, input logic [3:0] m0);
    return (h1 <= 2'd2) && (h0 <= 4'd9) && (to_bin({2'b00, h1}, h0) <= 6'd23) &&
           (m1 <= 4'd5) && (m0 <= 4'd9);
  endfunction

  // Tens digit of a 0..59 binary value.
  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    logic [3:0] t;
    logic [5:0] r;
    t = 4'd0;
    r = v;
    for (int i = 0; i < 5; i++) begin
      if (r >= 6'd10) begin
        r = r - 6'd10;
        t = t + 4'd1;
      end
    end
    return t;
  endfunction

  // Units digit of a 0..59 binary value.
  function automatic logic [3:0] bcd_units(input logic [5:0] v);
    logic [5:0] r;
    r = v - (6'(bcd_tens(v)) * 6'd10);
    return r[3:0];
  endfunction

  logic [5:0]          sec_r, min_r, hour_r;
  logic [5:0]          sec_nx_s, min_nx_s, hour_nx_s;
  logic [5:0]          slot_h_r [N_ALARMS];
  logic [5:0]          slot_m_r [N_ALARMS];
  state_t              state_r, state_nx_s;
  logic [AW-1:0]       alarm_id_r, alarm_id_nx_s;
  logic [11:0]         ring_cnt_r, ring_cnt_nx_s;
  logic [11:0]         snz_cnt_r, snz_cnt_nx_s;
  logic                load_err_r;

  logic                digits_ok_s, sel_ok_s;
  logic                time_ld_ok_s, alarm_ld_ok_s, load_err_nx_s;
  logic [5:0]          in_hour_s, in_min_s;
  logic [N_ALARMS-1:0] match_s;
  logic                hit_s;
  logic [AW-1:0]       hit_id_s;
  logic                id_en_s;

  assign digits_ok_s   = digits_ok(h_in1, h_in0, m_in1, m_in0);
  assign sel_ok_s      = ({{(32-AW){1'b0}}, alarm_sel} < 32'(N_ALARMS));
  assign time_ld_ok_s  = ld_time & digits_ok_s;
  assign alarm_ld_ok_s = ld_alarm & digits_ok_s & sel_ok_s;
  assign load_err_nx_s = (ld_time & ~digits_ok_s) | (ld_alarm & ~(digits_ok_s & sel_ok_s));
  assign in_hour_s     = to_bin({2'b00, h_in1}, h_in0);
  assign in_min_s      = to_bin(m_in1, m_in0);

  // Next time value: a valid ld_time replaces the increment for that edge.
  always_comb begin
    sec_nx_s  = sec_r;
    min_nx_s  = min_r;
    hour_nx_s = hour_r;
    if (time_ld_ok_s) begin
      sec_nx_s  = 6'd0;
      min_nx_s  = in_min_s;
      hour_nx_s = in_hour_s;
    end else if (sec_r == 6'd59) begin
      sec_nx_s = 6'd0;
      if (min_r == 6'd59) begin
        min_nx_s  = 6'd0;
        hour_nx_s = (hour_r == 6'd23) ? 6'd0 : hour_r + 6'd1;
      end else begin
        min_nx_s = min_r + 6'd1;
      end
    end else begin
      sec_nx_s = sec_r + 6'd1;
    end
  end

  // Slots are compared against the time about to be shown, so the alarm
  // rises on the same edge the display reaches hh:mm:00.
  always_comb begin
    match_s = {N_ALARMS{1'b0}};
    for (int k = 0; k < N_ALARMS; k++) begin
      match_s[k] = al_en[k] && (slot_h_r[k] == hour_nx_s) &&
                   (slot_m_r[k] == min_nx_s) && (sec_nx_s == 6'd0);
    end
  end

  // Lowest-numbered matching slot wins; scan from the top so it is written last.
  always_comb begin
    hit_s    = 1'b0;
    hit_id_s = {AW{1'b0}};
    for (int k = N_ALARMS - 1; k >= 0; k--) begin
      if (match_s[k]) begin
        hit_s    = 1'b1;
        hit_id_s = AW'(k);
      end else begin
        hit_s    = hit_s;
        hit_id_s = hit_id_s;
      end
    end
  end

  // Enable bit of the slot currently ringing or snoozing.
  always_comb begin
    id_en_s = 1'b0;
    for (int k = 0; k < N_ALARMS; k++) begin
      if (AW'(k) == alarm_id_r) begin
        id_en_s = al_en[k];
      end else begin
        id_en_s = id_en_s;
      end
    end
  end

  // Alarm FSM next state; counters only move in the state that owns them.
  always_comb begin
    state_nx_s    = state_r;
    alarm_id_nx_s = alarm_id_r;
    ring_cnt_nx_s = ring_cnt_r;
    snz_cnt_nx_s  = snz_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (hit_s) begin
          state_nx_s    = ST_RING;
          alarm_id_nx_s = hit_id_s;
          ring_cnt_nx_s = 12'd0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RING: begin
        if (stop_al) begin
          state_nx_s = ST_IDLE;
        end else if (!id_en_s) begin
          state_nx_s = ST_IDLE;
        end else if (snooze) begin
          state_nx_s   = ST_SNOOZE;
          snz_cnt_nx_s = SNZ_LOAD;
        end else if (ring_cnt_r == RING_LAST) begin
          state_nx_s = ST_IDLE;
        end else begin
          ring_cnt_nx_s = ring_cnt_r + 12'd1;
        end
      end
      ST_SNOOZE: begin
        if (stop_al || !id_en_s) begin
          state_nx_s = ST_IDLE;
        end else if (snz_cnt_r == 12'd0) begin
          state_nx_s    = ST_RING;
          ring_cnt_nx_s = 12'd0;
        end else begin
          snz_cnt_nx_s = snz_cnt_r - 12'd1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Time counters and load error pulse.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      sec_r      <= 6'd0;
      min_r      <= 6'd0;
      hour_r     <= 6'd0;
      load_err_r <= 1'b0;
    end else begin
      sec_r      <= sec_nx_s;
      min_r      <= min_nx_s;
      hour_r     <= hour_nx_s;
      load_err_r <= load_err_nx_s;
    end
  end

  // Alarm slot storage.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_ALARMS; k++) begin
        slot_h_r[k] <= 6'd0;
        slot_m_r[k] <= 6'd0;
      end
    end else begin
      for (int k = 0; k < N_ALARMS; k++) begin
        if (alarm_ld_ok_s && (alarm_sel == AW'(k))) begin
          slot_h_r[k] <= in_hour_s;
          slot_m_r[k] <= in_min_s;
        end
      end
    end
  end

  // Alarm FSM state and counters.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      alarm_id_r <= {AW{1'b0}};
      ring_cnt_r <= 12'd0;
      snz_cnt_r  <= 12'd0;
    end else begin
      state_r    <= state_nx_s;
      alarm_id_r <= alarm_id_nx_s;
      ring_cnt_r <= ring_cnt_nx_s;
      snz_cnt_r  <= snz_cnt_nx_s;
    end
  end

  assign h_out1   = 2'(bcd_tens(hour_r));
  assign h_out0   = bcd_units(hour_r);
  assign m_out1   = bcd_tens(min_r);
  assign m_out0   = bcd_units(min_r);
  assign s_out1   = bcd_tens(sec_r);
  assign s_out0   = bcd_units(sec_r);
  assign alarm    = (state_r == ST_RING);
  assign snoozing = (state_r == ST_SNOOZE);
  assign alarm_id = alarm_id_r;
  assign load_err = load_err_r;

endmodule

// File: tb/tb_aclock_multi_alarm.sv
// -----------------------------------------------------------------------------
// tb_aclock_multi_alarm
//   Table of load/validity vectors followed by hand-written multi-second
//   sequences (wrap, ring timeout, priority, snooze, reset while ringing).
//   Expectations are queued when stimulus is applied and checked 1 time unit
//   after the following rising edge. A second instance with three slots
//   exercises the out-of-range alarm_sel case.
// -----------------------------------------------------------------------------
module tb_aclock_multi_alarm;

  logic       clk_1s = 1'b0;
  logic       reset, ld_time, ld_alarm, stop_al, snooze;
  logic [1:0] alarm_sel, h_in1;
  logic [3:0] h_in0, m_in1, m_in0, al_en;
  logic [1:0] h_out1, alarm_id;
  logic [3:0] h_out0, m_out1, m_out0, s_out1, s_out0;
  logic       alarm, snoozing, load_err;

  logic [1:0] h3_1, id3;
  logic [3:0] h3_0, m3_1, m3_0, s3_1, s3_0;
  logic       al3, snz3, err3;

  always #5 clk_1s = ~clk_1s;

  aclock_multi_alarm #(.N_ALARMS(4), .AW(2), .SNOOZE_SEC(300), .RING_SEC(60)) u_dut (
    .clk_1s(clk_1s), .reset(reset), .ld_time(ld_time), .ld_alarm(ld_alarm),
    .alarm_sel(alarm_sel), .h_in1(h_in1), .h_in0(h_in0), .m_in1(m_in1), .m_in0(m_in0),
    .al_en(al_en), .stop_al(stop_al), .snooze(snooze),
    .h_out1(h_out1), .h_out0(h_out0), .m_out1(m_out1), .m_out0(m_out0),
    .s_out1(s_out1), .s_out0(s_out0), .alarm(alarm), .alarm_id(alarm_id),
    .snoozing(snoozing), .load_err(load_err)
  );

  aclock_multi_alarm #(.N_ALARMS(3), .AW(2), .SNOOZE_SEC(300), .RING_SEC(60)) u_dut3 (
    .clk_1s(clk_1s), .reset(reset), .ld_time(ld_time), .ld_alarm(ld_alarm),
    .alarm_sel(alarm_sel), .h_in1(h_in1), .h_in0(h_in0), .m_in1(m_in1), .m_in0(m_in0),
    .al_en(al_en[2:0]), .stop_al(stop_al), .snooze(snooze),
    .h_out1(h3_1), .h_out0(h3_0), .m_out1(m3_1), .m_out0(m3_0),
    .s_out1(s3_1), .s_out0(s3_0), .alarm(al3), .alarm_id(id3),
    .snoozing(snz3), .load_err(err3)
  );

  logic [21:0] act_t;
  assign act_t = {h_out1, h_out0, m_out1, m_out0, s_out1, s_out0};

  typedef struct {
    int          cyc;
    string       nm;
    logic [21:0] t;
    bit          al;
    bit [1:0]    id;
    bit          sn;
    bit          er;
    bit          c3;
    bit          e3;
  } exp_t;

  typedef struct {
    string    nm;
    bit       lt;
    bit       la;
    bit [1:0] sel;
    bit [1:0] h1;
    bit [3:0] h0, m1, m0;
    int       eh, em, es;
    bit       er, e3;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[13];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   th = 0, tm = 0, ts = 0;

  function automatic logic [21:0] tpack(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic push_exp(input string nm, input bit al, input bit [1:0] id, input bit sn,
                          input bit er, input bit c3, input bit e3);
    exp_t e;
    e.cyc = cyc + 1; e.nm = nm; e.t = tpack(th, tm, ts);
    e.al = al; e.id = id; e.sn = sn; e.er = er; e.c3 = c3; e.e3 = e3;
    sb.push_back(e);
  endtask

  task automatic tick_exp();
    ts++;
    if (ts == 60) begin
      ts = 0; tm++;
      if (tm == 60) begin
        tm = 0; th = (th == 23) ? 0 : th + 1;
      end
    end
  endtask

  task automatic set_exp(input int h, input int m);
    th = h; tm = m; ts = 0;
  endtask

  task automatic set_digits(input int h, input int m);
    h_in1 = 2'(h / 10); h_in0 = 4'(h % 10);
    m_in1 = 4'(m / 10); m_in0 = 4'(m % 10);
  endtask

  task automatic clear_pulses();
    ld_time = 1'b0; ld_alarm = 1'b0; stop_al = 1'b0; snooze = 1'b0;
  endtask

  // One edge: queue the expectation for the coming edge, advance to the next negedge.
  task automatic step(input string nm, input bit al, input bit [1:0] id, input bit sn);
    push_exp(nm, al, id, sn, 1'b0, 1'b0, 1'b0);
    @(negedge clk_1s);
    clear_pulses();
  endtask

  task automatic run(input int n, input string nm, input bit al, input bit [1:0] id, input bit sn);
    repeat (n) begin
      tick_exp();
      step(nm, al, id, sn);
    end
  endtask

  task automatic check_now(input string nm);
    cmp({nm, " time"}, 32'(act_t), 32'(tpack(0, 0, 0)));
    cmp({nm, " alarm"}, 32'(alarm), 32'd0);
    cmp({nm, " alarm_id"}, 32'(alarm_id), 32'd0);
    cmp({nm, " snoozing"}, 32'(snoozing), 32'd0);
    cmp({nm, " load_err"}, 32'(load_err), 32'd0);
  endtask

  // Scoreboard: pop every expectation due at this edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_1s);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        cmp({e.nm, " time"}, 32'(act_t), 32'(e.t));
        cmp({e.nm, " alarm"}, 32'(alarm), 32'(e.al));
        cmp({e.nm, " alarm_id"}, 32'(alarm_id), 32'(e.id));
        cmp({e.nm, " snoozing"}, 32'(snoozing), 32'(e.sn));
        cmp({e.nm, " load_err"}, 32'(load_err), 32'(e.er));
        if (e.c3) begin
          cmp({e.nm, " load_err(3 slots)"}, 32'(err3), 32'(e.e3));
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not complete, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t v;
    tbl[0]  = '{"ld 12:34",      1'b1, 1'b0, 2'd0, 2'd1, 4'd2, 4'd3, 4'd4, 12, 34, 0, 1'b0, 1'b0};
    tbl[1]  = '{"tick",          1'b0, 1'b0, 2'd0, 2'd1, 4'd2, 4'd3, 4'd4, 12, 34, 1, 1'b0, 1'b0};
    tbl[2]  = '{"ld 24:00",      1'b1, 1'b0, 2'd0, 2'd2, 4'd4, 4'd0, 4'd0, 12, 34, 2, 1'b1, 1'b1};
    tbl[3]  = '{"err pulse end", 1'b0, 1'b0, 2'd0, 2'd2, 4'd4, 4'd0, 4'd0, 12, 34, 3, 1'b0, 1'b0};
    tbl[4]  = '{"ld m0=10",      1'b1, 1'b0, 2'd0, 2'd1, 4'd2, 4'd3, 4'd10,12, 34, 4, 1'b1, 1'b1};
    tbl[5]  = '{"ld h1=3",       1'b1, 1'b0, 2'd0, 2'd3, 4'd0, 4'd0, 4'd0, 12, 34, 5, 1'b1, 1'b1};
    tbl[6]  = '{"ld m1=6",       1'b1, 1'b0, 2'd0, 2'd1, 4'd2, 4'd6, 4'd0, 12, 34, 6, 1'b1, 1'b1};
    tbl[7]  = '{"ld 19:59",      1'b1, 1'b0, 2'd0, 2'd1, 4'd9, 4'd5, 4'd9, 19, 59, 0, 1'b0, 1'b0};
    tbl[8]  = '{"al slot0 ok",   1'b0, 1'b1, 2'd0, 2'd0, 4'd5, 4'd0, 4'd0, 19, 59, 1, 1'b0, 1'b0};
    tbl[9]  = '{"al 24:00",      1'b0, 1'b1, 2'd1, 2'd2, 4'd4, 4'd0, 4'd0, 19, 59, 2, 1'b1, 1'b1};
    tbl[10] = '{"al sel range",  1'b0, 1'b1, 2'd3, 2'd0, 4'd5, 4'd0, 4'd0, 19, 59, 3, 1'b0, 1'b1};
    tbl[11] = '{"both 23:59",    1'b1, 1'b1, 2'd0, 2'd2, 4'd3, 4'd5, 4'd9, 23, 59, 0, 1'b0, 1'b0};
    tbl[12] = '{"both 25:00",    1'b1, 1'b1, 2'd1, 2'd2, 4'd5, 4'd0, 4'd0, 23, 59, 1, 1'b1, 1'b1};

    reset = 1'b1; clear_pulses();
    alarm_sel = 2'd0; al_en = 4'b0000; set_digits(0, 0);
    @(negedge clk_1s);
    check_now("reset");
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      v = tbl[i];
      ld_time = v.lt; ld_alarm = v.la; alarm_sel = v.sel;
      h_in1 = v.h1; h_in0 = v.h0; m_in1 = v.m1; m_in0 = v.m0;
      th = v.eh; tm = v.em; ts = v.es;
      push_exp(v.nm, 1'b0, 2'd0, 1'b0, v.er, 1'b1, v.e3);
      @(negedge clk_1s);
      clear_pulses();
    end

    // Midnight wrap from 23:59:01.
    run(58, "to 23:59:59", 1'b0, 2'd0, 1'b0);
    run(1, "wrap 00:00:00", 1'b0, 2'd0, 1'b0);
    run(1, "after wrap", 1'b0, 2'd0, 1'b0);

    // Slot 2 at 07:30, ring until timeout.
    ld_alarm = 1'b1; alarm_sel = 2'd2; set_digits(7, 30);
    tick_exp(); step("ld slot2", 1'b0, 2'd0, 1'b0);
    al_en = 4'b0100; ld_time = 1'b1; set_digits(7, 29); set_exp(7, 29);
    step("ld 07:29", 1'b0, 2'd0, 1'b0);
    run(59, "before 07:30", 1'b0, 2'd0, 1'b0);
    run(60, "ring slot2", 1'b1, 2'd2, 1'b0);
    run(1, "ring timeout", 1'b0, 2'd2, 1'b0);

    // Slots 1 and 3 both 06:00: lowest wins, stop_al ends it.
    al_en = 4'b0000;
    ld_alarm = 1'b1; alarm_sel = 2'd1; set_digits(6, 0);
    tick_exp(); step("ld slot1", 1'b0, 2'd2, 1'b0);
    ld_alarm = 1'b1; alarm_sel = 2'd3; set_digits(6, 0);
    tick_exp(); step("ld slot3", 1'b0, 2'd2, 1'b0);
    al_en = 4'b1010; ld_time = 1'b1; set_digits(5, 59); set_exp(5, 59);
    step("ld 05:59", 1'b0, 2'd2, 1'b0);
    run(59, "before 06:00", 1'b0, 2'd2, 1'b0);
    run(6, "ring lowest", 1'b1, 2'd1, 1'b0);
    stop_al = 1'b1;
    tick_exp(); step("stop_al", 1'b0, 2'd1, 1'b0);
    run(1, "idle after stop", 1'b0, 2'd1, 1'b0);

    // ld_time onto a matching slot rings at once; snooze and re-ring.
    al_en = 4'b0000;
    ld_alarm = 1'b1; alarm_sel = 2'd0; set_digits(8, 0);
    tick_exp(); step("ld slot0", 1'b0, 2'd1, 1'b0);
    al_en = 4'b0001; ld_time = 1'b1; set_digits(8, 0); set_exp(8, 0);
    step("ld_time match", 1'b1, 2'd0, 1'b0);
    run(2, "ring 08:00", 1'b1, 2'd0, 1'b0);
    snooze = 1'b1;
    tick_exp(); step("snooze", 1'b0, 2'd0, 1'b1);
    run(299, "snoozing", 1'b0, 2'd0, 1'b1);
    run(1, "re-ring", 1'b1, 2'd0, 1'b0);
    run(1, "ringing again", 1'b1, 2'd0, 1'b0);
    stop_al = 1'b1; snooze = 1'b1;
    tick_exp(); step("stop+snooze", 1'b0, 2'd0, 1'b0);

    // Dropping the enable of the ringing slot returns to idle.
    ld_time = 1'b1; set_digits(8, 0); set_exp(8, 0);
    step("ring 2nd", 1'b1, 2'd0, 1'b0);
    al_en = 4'b0000;
    tick_exp(); step("enable drop", 1'b0, 2'd0, 1'b0);

    // Reset while ringing clears everything immediately.
    al_en = 4'b0001; ld_time = 1'b1; set_digits(8, 0); set_exp(8, 0);
    step("ring 3rd", 1'b1, 2'd0, 1'b0);
    reset = 1'b1;
    #1;
    check_now("reset mid-ring");
    @(negedge clk_1s);
    reset = 1'b0;
    al_en = 4'b1000; ld_time = 1'b1; set_digits(0, 0); set_exp(0, 0);
    step("slot3 cleared", 1'b1, 2'd3, 1'b0);
    stop_al = 1'b1;
    tick_exp(); step("stop slot3", 1'b0, 2'd3, 1'b0);
    al_en = 4'b0001; ld_time = 1'b1; set_digits(0, 0); set_exp(0, 0);
    step("slot0 cleared", 1'b1, 2'd0, 1'b0);
    stop_al = 1'b1;
    tick_exp(); step("stop slot0", 1'b0, 2'd0, 1'b0);

    @(negedge clk_1s);
    @(negedge clk_1s);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
